seq_checker: RTL

SEQ_CHECKER -- requirements
Module: seq_checker

---
 rtl/seq_checker_pkg.sv | 15 +
 rtl/sat_cnt.sv | 30 +++
 rtl/seq_checker.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seq_checker_pkg.sv
// Shared constants for the recurrence checker: data width, parameter defaults and
// the acquisition/tracking state encoding.
package seq_checker_pkg;

    localparam int unsigned DataW    = 32;
    localparam int unsigned LockNDef = 4;
    localparam int unsigned CntWDef  = 16;
    localparam int unsigned RunW     = 4;

    localparam logic [1:0] StAcq0  = 2'd0;
    localparam logic [1:0] StAcq1  = 2'd1;
    localparam logic [1:0] StAcq2  = 2'd2;
    localparam logic [1:0] StTrack = 2'd3;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_checker.sv
// Checks a sample stream against a(n) = a(n-3) + a(n-2) after a 3-sample acquisition,
// reporting mismatches, match/error counts and a lock indication.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int unsigned LOCK_N = LockNDef,
    parameter int unsigned CNT_W  = CntWDef
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DataW-1:0] seq_i,
    input  logic             seq_vld_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [DataW-1:0] exp_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam logic [RunW-1:0] LockThr = RunW'(LOCK_N);

    logic [1:0]       state_q, state_d;
    logic [DataW-1:0] h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
    logic [DataW-1:0] exp_q, exp_d;
    logic [DataW-1:0] expected;
    logic [RunW-1:0]  run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             match_inc, err_inc;

    always_comb begin
        state_d   = state_q;
        h1_d      = h1_q;
        h2_d      = h2_q;
        h3_d      = h3_q;
        run_d     = run_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        match_inc = 1'b0;
        err_inc   = 1'b0;
        expected  = h1_q + h2_q;

        if (seq_vld_i) begin
            unique case (state_q)
                StAcq0: begin
                    h1_d    = seq_i;
                    state_d = StAcq1;
                end
                StAcq1: begin
                    h2_d    = seq_i;
                    state_d = StAcq2;
                end
                StAcq2: begin
                    h3_d    = seq_i;
                    state_d = StTrack;
                end
                StTrack: begin
                    // History always takes the received value, so a mismatch resyncs.
                    h1_d = h2_q;
                    h2_d = h3_q;
                    h3_d = seq_i;
                    if (seq_i == expected) begin
                        match_inc = 1'b1;
                        if (run_q != LockThr) begin
                            run_d = run_q + RunW'(1);
                        end
                        if (run_d == LockThr) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_d    = 1'b1;
                        err_inc  = 1'b1;
                        run_d    = '0;
                        locked_d = 1'b0;
                    end
                end
                default: state_d = StAcq0;
            endcase
        end

        exp_d = (state_d == StTrack) ? (h1_d + h2_d) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StAcq0;
            h1_q     <= '0;
            h2_q     <= '0;
            h3_q     <= '0;
            exp_q    <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            h3_q     <= h3_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    sat_cnt #(
        .Width (CNT_W)
    ) u_err_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt_o)
    );

    sat_cnt #(
        .Width (CNT_W)
    ) u_match_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (match_inc),
        .cnt_o  (match_cnt_o)
    );

    assign locked_o = locked_q;
    assign err_o    = err_q;
    assign exp_o    = exp_q;

endmodule
